// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   fetch_entry_t  : one queued fetch result {pc, instr}
//   ICACHE_*       : icache_status encodings
//   fetch_state_t  : fetch FSM states
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [1:0] ICACHE_IDLE = 2'b00;
    localparam logic [1:0] ICACHE_BUSY = 2'b01;
    localparam logic [1:0] ICACHE_DONE = 2'b10;

    typedef enum logic [0:0] {
        RUN,
        WAIT
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch_entry_t feeding decode.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the queue; wins over push/pop
//   push_data  : entry to enqueue
//   head       : head entry, all zeros when empty
//   count      : number of valid entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (push)   tail_d = tail_q + PW'(1);
            if (do_pop) head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; count gates visibility
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_q[tail_q] <= push_data;
        end
    end

    always_comb begin
        head  = (count_q == '0) ? '0 : mem_q[head_q];
        count = count_q;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of the L1 instruction cache.
// Holds the fetch PC, drives the cache address/stall, queues completed accesses
// for decode and handles backend redirects (abort access, flush queue).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   redirect_valid, redirect_pc   : backend redirect (pc[1:0] ignored)
//   icache_addr, icache_stall     : cache address (= pc) and hold/abort
//   icache_data, icache_status    : cache read data and status (00/01/10)
//   deq_valid, deq_ready          : decode handshake
//   deq_pc, deq_instr             : head entry (zero when empty)
//   perf_*                        : performance counters
// Build option: define FETCH_PERF_EN to build the perf counters; otherwise the
// perf_* outputs are tied to zero.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] icache_addr,
    output logic        icache_stall,
    input  logic [31:0] icache_data,
    input  logic [1:0]  icache_status,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_instr,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_redirect_count,
    output logic [31:0] perf_full_cycles
);

    localparam int unsigned    CW   = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        deq_valid  = (count != '0) && !redirect_valid;
        pop        = deq_valid && deq_ready;
        // Redirect drops any data completing in the same cycle
        push       = (state_q == RUN) && !redirect_valid && (icache_status == ICACHE_DONE);
        push_data  = '{pc: pc_q, instr: icache_data};
        count_next = count + CW'(push) - CW'(pop);

        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (push) begin
                pc_d = pc_q + 32'd4;
                if (count_next == FULL) state_d = WAIT;
            end
        end else if (count != FULL) begin
            // Decided on start-of-cycle count: WAIT always lasts past the freeing pop
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        icache_addr  = pc_q;
        icache_stall = rst || redirect_valid || (state_q == WAIT);
        deq_pc       = head.pc;
        deq_instr    = head.instr;
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic [31:0] full_cnt_q, full_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(push);
        redir_cnt_d = redir_cnt_q + 32'(redirect_valid);
        full_cnt_d  = full_cnt_q + 32'(state_q == WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign perf_fetch_count    = fetch_cnt_q;
    assign perf_redirect_count = redir_cnt_q;
    assign perf_full_cycles    = full_cnt_q;
`else
    assign perf_fetch_count    = '0;
    assign perf_redirect_count = '0;
    assign perf_full_cycles    = '0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch stage directly upstream of the L1 instruction cache. Holds the fetch PC, drives the cache address and stall lines, and captures each completed cache access into a small instruction queue that feeds decode. It also handles backend redirects (branch or exception) by aborting the in-flight access and flushing the queue.

## Interface

- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  backend redirect request
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0
- icache_addr  out  32  fetch address to the cache; equals the PC register
- icache_stall  out  1  holds or aborts the cache access
- icache_data  in  32  cache read data
- icache_status  in  2  cache status: 00 idle, 01 busy, 10 data valid for one cycle
- deq_valid  out  1  queue head valid
- deq_ready  in  1  decode accepts the head entry
- deq_pc  out  32  PC of the head entry
- deq_instr  out  32  instruction of the head entry
- perf_fetch_count  out  32  instructions enqueued
- perf_redirect_count  out  32  redirects taken
- perf_full_cycles  out  32  cycles spent in WAIT

## Operation

- State machine states: RUN and WAIT.
- RUN:
  - icache_stall = 0; the cache runs its own 00→01→10→00 sequence.
  - On a cycle with icache_status == 10, push {pc, icache_data} into the queue and set pc <= pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
  - If the push makes the count reach QUEUE_DEPTH (after any same-cycle dequeue), go to WAIT.
- WAIT:
  - icache_stall = 1.
  - When count < QUEUE_DEPTH at the start of a cycle, go to RUN on the next edge.
- Space guarantee: RUN is only entered with count < QUEUE_DEPTH, and the only push is the single in-flight access. Overflow is therefore impossible; the verifier asserts this.
- Redirect, in either state, takes priority over everything else:
  - icache_stall = 1 in that cycle, which aborts the access.
  - Queue is flushed (count <= 0).
  - pc <= {redirect_pc[31:2], 2'b00}.
  - State <= RUN.
  - Any icache_status == 10 data arriving in the same cycle is dropped.
  - deq_valid is forced to 0 combinationally during redirect, so no dequeue happens.
- Queue:
  - Circular buffer with head and tail pointers and a count of width $clog2(QUEUE_DEPTH)+1.
  - deq_valid = (count != 0) && !redirect_valid.
  - A dequeue occurs when deq_valid && deq_ready.
  - Simultaneous push and dequeue leaves count unchanged. Pointers wrap modulo QUEUE_DEPTH.
  - deq_pc and deq_instr are 0 whenever count == 0.
- icache_addr is combinational from the pc register. It is stable for the whole access because pc changes only on completion or redirect.

## Timing

- Reset values:
  - pc = RESET_PC, state = RUN, count = 0.
  - deq_valid = 0, deq_pc = 0, deq_instr = 0.
  - icache_addr = RESET_PC, icache_stall = 1 while rst is high.
  - All perf counters = 0.
- Reset mid-access: the cache is also reset, so the access is discarded silently.
- Enqueue latency: data sampled on the status-10 edge appears on deq_* in the next cycle.
- The new pc is presented in the same cycle the cache returns to 00, so the cache's hit check uses the new address.
- Throughput: one instruction per full cache access sequence; WAIT adds at least one cycle after space frees.
- Redirect: the first access to the target begins in the cycle after redirect_valid.

## Configuration

- FETCH_PERF_EN defined:
  - perf_fetch_count increments on every push.
  - perf_redirect_count increments on every redirect cycle.
  - perf_full_cycles increments on every WAIT cycle.
  - Counters wrap at 2^32 and are not cleared by redirect.
- FETCH_PERF_EN not defined: the perf_* ports remain present, tied to 32'b0, and no counter registers are built.

## Structure

- Package fetch_pkg:
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}.
  - ICACHE_IDLE, ICACHE_BUSY and ICACHE_DONE status constants (2'b00/01/10).
  - fetch_state_t enum {RUN, WAIT}.
- Sub-module fetch_queue: a parameterised FIFO of fetch_entry_t with push/pop/flush inputs, count output, and zeroed head output when empty.

## Test plan

- Reset release with a cache model returning 32'h2402_0001 at 32'hBFC0_0000 and deq_ready = 1 → first deq has pc = 32'hBFC0_0000, instr = 32'h2402_0001; next fetch address is 32'hBFC0_0004.
- deq_ready = 0 for 20 accesses, QUEUE_DEPTH = 4 → exactly 4 entries, PCs 0xBFC0_0000…0xBFC0_000C in order; icache_stall = 1 (WAIT); one dequeue → RUN and the fifth fetch is at 0xBFC0_0010.
- redirect_valid with redirect_pc = 32'h8000_0103 while the cache is busy and the queue holds 2 entries → queue empties, the next access address is 32'h8000_0100, and the first dequeued pc is 32'h8000_0100.
- redirect_valid in the same cycle as icache_status = 10 and deq_ready = 1 → no push, no dequeue, and deq_valid = 0 that cycle.
- pc = 32'hFFFF_FFFC via redirect, then one completed access → the next icache_addr is 32'h0000_0000.
- With FETCH_PERF_EN: 6 pushes, 1 redirect, 3 WAIT cycles → counters read 6, 1, 3. Without FETCH_PERF_EN all three read 0.
